// File: rtl/instr_decode_stage.sv
// Single-register instruction decode stage: splits the raw word into fields,
// flags illegal opcodes and RAW hazards, and counts accepted instructions.
module instr_decode_stage #(
    parameter int OP_W    = 5,
    parameter int REG_W   = 5,
    parameter int INSTR_W = 32,
    parameter int DATA_W  = 32,
    parameter int NUM_OPS = 21,
    parameter int CNT_W   = 16
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [INSTR_W-1:0] instr,
    input  logic               in_valid,
    output logic               in_ready,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [OP_W-1:0]    op,
    output logic [REG_W-1:0]   op1,
    output logic [REG_W-1:0]   op2,
    output logic [REG_W-1:0]   rd,
    output logic               is_imm,
    output logic [DATA_W-1:0]  imm,
    output logic               illegal,
    output logic               hazard,
    output logic [CNT_W-1:0]   instr_count
);

    localparam int IMM_LO = 3*REG_W + OP_W;
    localparam int IMM_W  = INSTR_W - 1 - IMM_LO;
    localparam logic [OP_W:0] NUM_OPS_L = (OP_W+1)'(NUM_OPS);

    logic [OP_W-1:0]   op_d,  op_q;
    logic [REG_W-1:0]  op1_d, op1_q;
    logic [REG_W-1:0]  op2_d, op2_q;
    logic [REG_W-1:0]  rd_d,  rd_q;
    logic              is_imm_d, is_imm_q;
    logic [DATA_W-1:0] imm_d, imm_q;
    logic              illegal_d, illegal_q;
    logic              hazard_d, hazard_q;
    logic              out_valid_q;
    logic [REG_W-1:0]  last_rd_q;
    logic              last_rd_valid_q;
    logic [CNT_W-1:0]  cnt_q;
    logic              xfer;

    // Ready is held high through reset so an upstream producer never sees a stall there.
    assign in_ready = rst || !out_valid_q || out_ready;
    assign xfer     = in_valid && in_ready && !rst;

    always_comb begin
        rd_d      = instr[REG_W-1:0];
        op1_d     = instr[3*REG_W-1:2*REG_W];
        op_d      = instr[IMM_LO-1:3*REG_W];
        is_imm_d  = instr[INSTR_W-1];
        op2_d     = is_imm_d ? '0 : instr[2*REG_W-1:REG_W];
        imm_d     = '0;
        if (is_imm_d)
            imm_d = {{(DATA_W-IMM_W){instr[INSTR_W-2]}}, instr[INSTR_W-2:IMM_LO]};
        illegal_d = ({1'b0, op_d} >= NUM_OPS_L);
        hazard_d  = last_rd_valid_q && (last_rd_q != '0) &&
                    ((last_rd_q == op1_d) || (!is_imm_d && (last_rd_q == op2_d)));
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            op_q            <= '0;
            op1_q           <= '0;
            op2_q           <= '0;
            rd_q            <= '0;
            is_imm_q        <= 1'b0;
            imm_q           <= '0;
            illegal_q       <= 1'b0;
            hazard_q        <= 1'b0;
            out_valid_q     <= 1'b0;
            last_rd_q       <= '0;
            last_rd_valid_q <= 1'b0;
            cnt_q           <= '0;
        end else if (xfer) begin
            op_q            <= op_d;
            op1_q           <= op1_d;
            op2_q           <= op2_d;
            rd_q            <= rd_d;
            is_imm_q        <= is_imm_d;
            imm_q           <= imm_d;
            illegal_q       <= illegal_d;
            hazard_q        <= hazard_d;
            out_valid_q     <= 1'b1;
            last_rd_q       <= rd_d;
            last_rd_valid_q <= 1'b1;
            if (cnt_q != '1)
                cnt_q <= cnt_q + CNT_W'(1);
        end else begin
            if (out_valid_q && out_ready)
                out_valid_q <= 1'b0;
            // An empty, idle cycle means the previous producer has left the pipe.
            if (!out_valid_q)
                last_rd_valid_q <= 1'b0;
        end
    end

    assign op          = op_q;
    assign op1         = op1_q;
    assign op2         = op2_q;
    assign rd          = rd_q;
    assign is_imm      = is_imm_q;
    assign imm         = imm_q;
    assign illegal     = illegal_q;
    assign hazard      = hazard_q;
    assign out_valid   = out_valid_q;
    assign instr_count = cnt_q;

endmodule

// File: doc/instr_decode_stage.md
INSTR_DECODE_STAGE -- requirements
Module: instr_decode_stage

Interface
REQ-001 Parameter OP_W, default 5, opcode field width.
REQ-002 Parameter REG_W, default 5, register-address field width.
REQ-003 Parameter INSTR_W, default 32, instruction width; SHALL satisfy INSTR_W >= 3*REG_W+OP_W+2.
REQ-004 Parameter DATA_W, default 32, sign-extended immediate width.
REQ-005 Parameter NUM_OPS, default 21, count of legal opcodes 0..NUM_OPS-1.
REQ-006 Parameter CNT_W, default 16, accepted-instruction counter width.
REQ-007 Clocking: one clock; reset is synchronous and active-high.
REQ-008 clk  in  1  rising-edge clock.
REQ-009 rst  in  1  synchronous active-high reset.
REQ-010 instr  in  INSTR_W  raw instruction.
REQ-011 in_valid  in  1  instr valid.
REQ-012 in_ready  out  1  stage can accept.
REQ-013 out_valid  out  1  decoded fields valid.
REQ-014 out_ready  in  1  consumer accepts.
REQ-015 op  out  OP_W  opcode.
REQ-016 op1  out  REG_W  source 1 address.
REQ-017 op2  out  REG_W  source 2 address; 0 in I-type.
REQ-018 rd  out  REG_W  destination address.
REQ-019 is_imm  out  1  I-type flag.
REQ-020 imm  out  DATA_W  sign-extended immediate; 0 in R-type.
REQ-021 illegal  out  1  op >= NUM_OPS.
REQ-022 hazard  out  1  RAW dependency on previous issued instruction.
REQ-023 instr_count  out  CNT_W  accepted instructions, saturating.

Function
REQ-024 Field map: rd=instr[REG_W-1:0], op2=next REG_W bits, op1=next REG_W bits, op=instr[3*REG_W+OP_W-1:3*REG_W].
REQ-025 Mode bit instr[INSTR_W-1]: 0 = R-type, 1 = I-type.
REQ-026 I-type imm = instr[INSTR_W-2:3*REG_W+OP_W] sign-extended to DATA_W; op2 output forced 0.
REQ-027 Single output register; in_ready = !out_valid || out_ready (combinational).
REQ-028 Transfer in on in_valid && in_ready; all outputs update on the following rising edge; latency 1 cycle.
REQ-029 out_valid set on transfer in; cleared when out_valid && out_ready with no simultaneous transfer in.
REQ-030 Simultaneous out-handshake and transfer in: register reloads, out_valid stays 1, no bubble.
REQ-031 While out_valid && !out_ready all outputs SHALL hold stable.
REQ-032 illegal registered with fields; illegal instructions still pass through and count.
REQ-033 Stage keeps last_rd/last_rd_valid of the most recently accepted instruction, set on every transfer in.
REQ-034 hazard = last_rd_valid && last_rd != 0 && (last_rd == op1 || (!is_imm && last_rd == op2)), evaluated against the incoming instruction at transfer in and registered with it.
REQ-035 last_rd_valid SHALL clear after a cycle with out_valid=0 and no transfer in (pipeline drained).
REQ-036 instr_count increments by 1 per transfer in; saturates at 2^CNT_W-1, no wrap.

Reset
REQ-037 rst=1 at a rising edge: out_valid=0, all field outputs, is_imm, imm, illegal, hazard = 0, last_rd_valid=0, instr_count=0.
REQ-038 in_ready = 1 during and after reset; transfer in ignored in the reset cycle.
REQ-039 Reset mid-stall discards the held instruction; no output handshake occurs for it.

Verification
REQ-040 R-type: instr=0x00008864, in_valid=1, out_ready=1 -> next cycle op=1, op1=2, op2=3, rd=4, is_imm=0, imm=0, illegal=0, out_valid=1.
REQ-041 I-type: instr=0xFFF11C09 -> op=2, op1=7, op2=0, rd=9, is_imm=1, imm=0xFFFFFFFF.
REQ-042 Back-pressure: out_ready=0 for 3 cycles with new instr offered -> in_ready=0, outputs frozen, instr_count unchanged; out_ready=1 -> next instr loads without bubble.
REQ-043 Hazard: accept rd=4, then op1=4 back-to-back -> hazard=1; repeat with rd=0 -> hazard=0; with a drained gap -> hazard=0.
REQ-044 Illegal/counter: op=21 -> illegal=1; CNT_W=2 with 5 accepts -> instr_count=3.
REQ-045 Reset asserted while out_valid=1 and out_ready=0 -> next cycle out_valid=0, instr_count=0, in_ready=1.
